// File: rtl/writeback_unit.sv
// Two-stage register-writeback pipeline: result source select, load extraction/merge,
// error flagging, valid/ready flow control with flush and a forwarding view of stage 2.
module writeback_unit #(
    parameter int DATA_BITS     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int LINK_OFFSET   = 4,
    localparam int N            = DATA_BITS / 8,
    localparam int LB           = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [DATA_BITS-1:0]     alu_out,
    input  logic [DATA_BITS-1:0]     mem_out,
    input  logic [DATA_BITS-1:0]     lo,
    input  logic [DATA_BITS-1:0]     hi,
    input  logic [DATA_BITS-1:0]     rt_old,
    input  logic [DATA_BITS-1:0]     pc,
    input  logic [LB-1:0]            addr_byte,
    input  logic [REG_ADDR_BITS-1:0] dst_reg,
    input  logic                     reg_write,
    input  logic [2:0]               src_sel,
    input  logic [2:0]               extr_mode,
    input  logic                     extr_signed,
    input  logic                     wb_stall,
    output logic                     wb_valid,
    output logic                     wb_en,
    output logic [REG_ADDR_BITS-1:0] wb_addr,
    output logic [DATA_BITS-1:0]     wb_data,
    output logic                     wb_reg_write,
    output logic                     wb_err,
    output logic                     fwd_valid,
    output logic [REG_ADDR_BITS-1:0] fwd_addr,
    output logic [DATA_BITS-1:0]     fwd_data
);
    logic                     s1_valid_reg;
    logic [DATA_BITS-1:0]     s1_alu_reg, s1_mem_reg, s1_lo_reg, s1_hi_reg, s1_rt_reg, s1_pc_reg;
    logic [LB-1:0]            s1_byte_reg;
    logic [REG_ADDR_BITS-1:0] s1_dst_reg;
    logic                     s1_wr_reg, s1_signed_reg;
    logic [2:0]               s1_src_reg, s1_mode_reg;

    logic                     s2_valid_reg;
    logic [REG_ADDR_BITS-1:0] wb_addr_reg;
    logic [DATA_BITS-1:0]     wb_data_reg;
    logic                     wb_err_reg, wb_wr_reg;

    logic                     s2_adv;
    logic [DATA_BITS-1:0]     res_data_next;
    logic                     res_err_next;
    logic [DATA_BITS-1:0]     lwl_shift, lwr_shift, lwl_merge, lwr_merge;
    logic [31:0]              b_ext;
    logic [7:0]               sel_byte;
    logic [15:0]              sel_half;

    assign s2_adv   = !s2_valid_reg || !wb_stall;
    assign in_ready = !s1_valid_reg || s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_alu_reg    <= '0;
            s1_mem_reg    <= '0;
            s1_lo_reg     <= '0;
            s1_hi_reg     <= '0;
            s1_rt_reg     <= '0;
            s1_pc_reg     <= '0;
            s1_byte_reg   <= '0;
            s1_dst_reg    <= '0;
            s1_wr_reg     <= 1'b0;
            s1_signed_reg <= 1'b0;
            s1_src_reg    <= '0;
            s1_mode_reg   <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_alu_reg    <= alu_out;
                s1_mem_reg    <= mem_out;
                s1_lo_reg     <= lo;
                s1_hi_reg     <= hi;
                s1_rt_reg     <= rt_old;
                s1_pc_reg     <= pc;
                s1_byte_reg   <= addr_byte;
                s1_dst_reg    <= dst_reg;
                s1_wr_reg     <= reg_write;
                s1_signed_reg <= extr_signed;
                s1_src_reg    <= src_sel;
                s1_mode_reg   <= extr_mode;
            end
        end
    end

    // lwr_shift brings lane b down to lane 0; lwl_shift lifts lane 0 up to lane N-1-b.
    assign b_ext     = 32'(s1_byte_reg);
    assign lwr_shift = s1_mem_reg >> {s1_byte_reg, 3'b000};
    assign lwl_shift = s1_mem_reg << {~s1_byte_reg, 3'b000};
    assign sel_byte  = lwr_shift[7:0];
    assign sel_half  = lwr_shift[15:0];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign lwl_merge[8*gi +: 8] = ((32'(gi) + b_ext) >= 32'(N - 1)) ?
                                          lwl_shift[8*gi +: 8] : s1_rt_reg[8*gi +: 8];
            assign lwr_merge[8*gi +: 8] = ((32'(gi) + b_ext) < 32'(N)) ?
                                          lwr_shift[8*gi +: 8] : s1_rt_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        res_data_next = '0;
        res_err_next  = 1'b0;
        case (s1_src_reg)
            3'd0: res_data_next = s1_alu_reg;
            3'd1: begin
                case (s1_mode_reg)
                    3'd0: res_data_next = s1_mem_reg;
                    3'd1: res_data_next = {{(DATA_BITS-8){s1_signed_reg & sel_byte[7]}}, sel_byte};
                    3'd2: begin
                        if (s1_byte_reg[0])
                            res_err_next = 1'b1;
                        else
                            res_data_next = {{(DATA_BITS-16){s1_signed_reg & sel_half[15]}}, sel_half};
                    end
                    3'd3:    res_data_next = lwl_merge;
                    3'd4:    res_data_next = lwr_merge;
                    default: res_err_next  = 1'b1;
                endcase
            end
            3'd2:    res_data_next = s1_lo_reg;
            3'd3:    res_data_next = s1_hi_reg;
            3'd4:    res_data_next = s1_pc_reg + DATA_BITS'(LINK_OFFSET);
            default: res_err_next  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
            wb_err_reg   <= 1'b0;
            wb_wr_reg    <= 1'b0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                wb_addr_reg <= s1_dst_reg;
                wb_data_reg <= res_data_next;
                wb_err_reg  <= res_err_next;
                wb_wr_reg   <= s1_wr_reg;
            end
        end
    end

    assign wb_valid     = s2_valid_reg;
    assign wb_addr      = wb_addr_reg;
    assign wb_data      = wb_data_reg;
    assign wb_err       = wb_err_reg;
    assign wb_reg_write = wb_wr_reg;
    assign wb_en        = s2_valid_reg && wb_wr_reg && (wb_addr_reg != '0) && !wb_err_reg;
    assign fwd_valid    = wb_en;
    assign fwd_addr     = wb_addr_reg;
    assign fwd_data     = wb_data_reg;
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Pipelined register-writeback stage for the MIPS core. It sits between the MEM stage outputs and the register-file write port. It selects the result source (ALU, memory, LO, HI or link address), extracts and extends load data, merges unaligned LWL/LWR loads with the old destination value, and flags misaligned or undefined loads. It has two register stages with valid/ready flow control, a flush input and a forwarding view of the in-flight result.

## Interface
- DATA_BITS, 32, datapath width; multiple of 16, at least 32; N = DATA_BITS/8 byte lanes
- REG_ADDR_BITS, 5, register index width
- LINK_OFFSET, 4, added to pc for link writes (pc already points to the next instruction)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage 1 accepts this cycle
- flush  in  1  kill everything in flight
- alu_out, mem_out, lo, hi, rt_old, pc  in  DATA_BITS each  candidate data; rt_old is the current destination value for LWL/LWR
- addr_byte  in  log2(N)  low address bits of the load
- dst_reg  in  REG_ADDR_BITS  destination index
- reg_write  in  1  instruction writes a register
- src_sel  in  3  0 ALU, 1 memory, 2 LO, 3 HI, 4 link; 5-7 undefined
- extr_mode  in  3  applies when src_sel=1: 0 full word, 1 byte, 2 halfword, 3 LWL, 4 LWR; 5-7 undefined
- extr_signed  in  1  sign-extend byte/halfword
- wb_stall  in  1  register file cannot take a write this cycle
- wb_valid  out  1  stage 2 holds a result
- wb_en  out  1  wb_valid & wb_reg_write & (wb_addr != 0) & !wb_err
- wb_addr  out  REG_ADDR_BITS  destination
- wb_data  out  DATA_BITS  result
- wb_reg_write  out  1  registered reg_write
- wb_err  out  1  misaligned halfword, or undefined src_sel/extr_mode
- fwd_valid, fwd_addr, fwd_data  out  1/REG_ADDR_BITS/DATA_BITS  equal to wb_en / wb_addr / wb_data, for hazard forwarding

## Operation
- Stage 1 registers all inputs unmodified, together with s1_valid.
- Stage 2 computes the result from the stage 1 registers and registers it into the wb_* outputs with s2_valid (= wb_valid).
- Source selection:
  - ALU: alu_out.
  - LO / HI: lo / hi.
  - Link: pc + LINK_OFFSET, modulo 2^DATA_BITS.
  - Undefined src_sel: data 0, err=1.
- Memory extraction, byte lane b = addr_byte; lane 0 = mem_out[7:0] (little-endian):
  - Byte: lane b, zero- or sign-extended.
  - Halfword: requires b[0]=0; uses halfword b>>1, zero- or sign-extended. If b[0]=1: data 0, err=1.
  - LWL: upper b+1 bytes of the result = mem_out lanes 0..b; lower N-1-b bytes = rt_old lanes 0..N-2-b.
  - LWR: lower N-b bytes of the result = mem_out lanes b..N-1; upper b bytes = rt_old upper b bytes.
  - Undefined extr_mode: data 0, err=1.
- Flow control:
  - s2 advances when !s2_valid | !wb_stall.
  - s1 advances when s2 advances.
  - in_ready = !s1_valid | s1 advances; this is combinational and must not depend on in_valid.
  - A stage that does not advance holds all of its registers unchanged.
- Flush: at the next edge, s1_valid=0 and s2_valid=0. Flush takes priority over a simultaneous accept, so the incoming instruction is dropped. The result in stage 2 is considered consumed in the flush cycle only if wb_stall=0.

## Timing
- Reset (asynchronous): s1_valid, wb_valid, wb_en, wb_err, wb_reg_write and fwd_valid = 0; wb_addr, wb_data, fwd_addr and fwd_data = 0. in_ready = 1 immediately.
- Latency is 2 cycles: accepted at edge k, result visible on wb_* after edge k+1.
- Throughput is 1 per cycle while wb_stall=0.
- Under wb_stall=1 with both stages full, in_ready=0; the wb_* outputs stay stable until the edge where wb_stall=0.
- A write to register 0 keeps wb_valid=1 but gives wb_en=0.
- Reset asserted mid-stream discards both stages; nothing is written after release.

## Test plan
- Back-to-back ALU writes to r3, r4, r5 (values 0x11, 0x22, 0x33), wb_stall=0 -> wb_en high on three consecutive cycles with matching addr/data, 2 cycles after each accept.
- Byte load, mem_out=0x80FF7F01, b=3, signed -> 0xFFFFFF80; b=2, unsigned -> 0x000000FF; halfword, b=2, signed -> 0xFFFF80FF; halfword, b=1 -> wb_err=1, wb_en=0.
- mem_out=0xAABBCCDD, rt_old=0x11223344: LWL b=0 -> 0xDD223344, LWL b=3 -> 0xAABBCCDD; LWR b=0 -> 0xAABBCCDD, LWR b=3 -> 0x112233AA.
- Link with pc=0xFFFFFFFC -> 0x00000000 (wrap); LO=0x5, HI=0x6 selected -> 0x5 / 0x6.
- Fill both stages, hold wb_stall=1 for 3 cycles -> in_ready=0 and wb_* stable; release -> both results drain in order, no duplicates.
- flush asserted together with in_valid while both stages are full -> next cycle wb_valid=0, wb_en=0, and the flushed instruction never appears on wb_*. rst pulse mid-stream -> all outputs 0 asynchronously.
